// File: rtl/pixel_array_ctrl.sv
// Exposure/readout sequencer for the photodiode pixel array.
// Runs erase -> exposure -> row-by-row readout and drives the active-low row
// enables and the ADC convert strobe. Supports abort and continuous capture.
module pixel_array_ctrl #(
  parameter int unsigned N_ROWS     = 2,
  parameter int unsigned EXP_W      = 5,
  parameter int unsigned ADC_CYCLES = 1,
  parameter int unsigned ERASE_MIN  = 2,
  localparam int unsigned ROW_W     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Init,
  input  logic [EXP_W-1:0]  i_Exp_Time,
  input  logic              i_Continuous,
  input  logic              i_Abort,
  output logic [N_ROWS-1:0] o_NRE,
  output logic              o_ADC,
  output logic              o_Expose,
  output logic              o_Erase,
  output logic [1:0]        o_Main_FSM,
  output logic [ROW_W-1:0]  o_Row,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam int unsigned ADC_W   = $clog2(ADC_CYCLES + 1);
  localparam int unsigned ERASE_W = $clog2(ERASE_MIN + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXPOSURE = 2'b01,
    ST_READOUT  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    PH_SELECT  = 2'b00,
    PH_CONVERT = 2'b01,
    PH_GAP     = 2'b10
  } phase_t;

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADC_W-1:0]    adc_cnt_q, adc_cnt_d;
  logic [EXP_W-1:0]    exp_cnt_q, exp_cnt_d;
  logic [ERASE_W-1:0]  erase_cnt_q, erase_cnt_d;
  logic [ERASE_W-1:0]  erase_inc;

  logic [N_ROWS-1:0]   nre_q, nre_d;
  logic                adc_q, adc_d;
  logic                expose_q, expose_d;
  logic                erase_q, erase_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    row_d       = row_q;
    adc_cnt_d   = adc_cnt_q;
    exp_cnt_d   = exp_cnt_q;
    erase_cnt_d = '0;
    done_d      = 1'b0;
    erase_inc   = (erase_cnt_q >= ERASE_W'(ERASE_MIN)) ? erase_cnt_q
                                                       : erase_cnt_q + ERASE_W'(1);

    case (state_q)
      ST_IDLE: begin
        // The current IDLE cycle counts toward the erase minimum
        erase_cnt_d = erase_inc;
        if ((erase_inc == ERASE_W'(ERASE_MIN)) && (i_Init || i_Continuous)) begin
          state_d   = ST_EXPOSURE;
          // Counter holds remaining cycles minus one; zero exposure acts as one
          exp_cnt_d = (i_Exp_Time == '0) ? '0 : i_Exp_Time - EXP_W'(1);
        end
      end

      ST_EXPOSURE: begin
        if (i_Abort) begin
          state_d = ST_IDLE;
        end else if (exp_cnt_q == '0) begin
          state_d = ST_READOUT;
          phase_d = PH_SELECT;
          row_d   = '0;
        end else begin
          exp_cnt_d = exp_cnt_q - EXP_W'(1);
        end
      end

      ST_READOUT: begin
        if (i_Abort) begin
          state_d = ST_IDLE;
        end else begin
          case (phase_q)
            PH_SELECT: begin
              phase_d   = PH_CONVERT;
              adc_cnt_d = ADC_W'(ADC_CYCLES - 1);
            end
            PH_CONVERT: begin
              if (adc_cnt_q == '0) begin
                phase_d = PH_GAP;
              end else begin
                adc_cnt_d = adc_cnt_q - ADC_W'(1);
              end
            end
            PH_GAP: begin
              if (row_q == ROW_W'(N_ROWS - 1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                row_d   = row_q + ROW_W'(1);
                phase_d = PH_SELECT;
              end
            end
            default: phase_d = PH_SELECT;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Row index reads as zero outside readout
    if (state_d != ST_READOUT) begin
      row_d   = '0;
      phase_d = PH_SELECT;
    end

    nre_d = '1;
    if ((state_d == ST_READOUT) && (phase_d != PH_GAP)) begin
      for (int unsigned k = 0; k < N_ROWS; k++) begin
        if (row_d == ROW_W'(k)) begin
          nre_d[k] = 1'b0;
        end
      end
    end
    adc_d    = (state_d == ST_READOUT) && (phase_d == PH_CONVERT);
    expose_d = (state_d == ST_EXPOSURE);
    erase_d  = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, counters and output registers with synchronous active-low reset
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_SELECT;
      row_q       <= '0;
      adc_cnt_q   <= '0;
      exp_cnt_q   <= '0;
      erase_cnt_q <= '0;
      nre_q       <= '1;
      adc_q       <= 1'b0;
      expose_q    <= 1'b0;
      erase_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      row_q       <= row_d;
      adc_cnt_q   <= adc_cnt_d;
      exp_cnt_q   <= exp_cnt_d;
      erase_cnt_q <= erase_cnt_d;
      nre_q       <= nre_d;
      adc_q       <= adc_d;
      expose_q    <= expose_d;
      erase_q     <= erase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_NRE      = nre_q;
  assign o_ADC      = adc_q;
  assign o_Expose   = expose_q;
  assign o_Erase    = erase_q;
  assign o_Main_FSM = state_q;
  assign o_Row      = row_q;
  assign o_Busy     = busy_q;
  assign o_Done     = done_q;

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Parametrised exposure/readout controller for the photodiode pixel array. It sequences erase, exposure and row-by-row readout for `N_ROWS` rows and drives the active-low row enables and the ADC strobe. The exposure timer and readout sequencer are internal, and the block adds abort and continuous-capture modes. It sits between the top-level capture control (`i_Init`) and the analog pixel/ADC front end.

## Interface
- `N_ROWS`, 2: number of pixel rows; must be ≥1.
- `EXP_W`, 5: width of the exposure-time input.
- `ADC_CYCLES`, 1: cycles `o_ADC` is held high per row; must be ≥1.
- `ERASE_MIN`, 2: minimum IDLE cycles with `o_Erase` high before a new exposure may start; must be ≥1.
- `ROW_W`, derived: `max(1, $clog2(N_ROWS))`.

Ports:
- `i_Clock`  in  1  single clock, rising edge.
- `i_Reset_n`  in  1  reset, synchronous, active-low.
- `i_Init`  in  1  start request; level-sampled in IDLE.
- `i_Exp_Time`  in  EXP_W  exposure length in cycles, latched at start.
- `i_Continuous`  in  1  auto-restart after each frame.
- `i_Abort`  in  1  terminate the current frame.
- `o_NRE`  out  N_ROWS  row enables, active-low; bit k is row k.
- `o_ADC`  out  1  ADC convert strobe.
- `o_Expose`  out  1  photodiode integrate.
- `o_Erase`  out  1  capacitor discharge.
- `o_Main_FSM`  out  2  state: 00 IDLE, 01 EXPOSURE, 10 READOUT.
- `o_Row`  out  ROW_W  row currently being read; 0 outside READOUT.
- `o_Busy`  out  1  high in EXPOSURE or READOUT.
- `o_Done`  out  1  one-cycle pulse on normal frame completion.

## Operation
- All outputs are registered. Reset values: `o_NRE` all ones, `o_ADC`=0, `o_Expose`=0, `o_Erase`=1, `o_Main_FSM`=00, `o_Row`=0, `o_Busy`=0, `o_Done`=0. The erase counter clears to 0.
- **IDLE:** `o_Erase`=1, `o_Expose`=0, `o_NRE` all ones, `o_ADC`=0. The erase counter increments and saturates at `ERASE_MIN`.
  - A start occurs when the erase counter has reached `ERASE_MIN` and either `i_Init`=1 or `i_Continuous`=1.
  - `i_Init` before the counter saturates is ignored. It is not remembered; a held level starts the frame once the counter saturates.
- **Start:** latch `T = (i_Exp_Time==0) ? 1 : i_Exp_Time` and move to EXPOSURE.
- **EXPOSURE:** `o_Expose`=1, `o_Erase`=0 for exactly T cycles, then move to READOUT.
- **READOUT:** rows are read in order 0..N_ROWS-1. Each row k takes ADC_CYCLES+2 cycles:
  - SELECT, 1 cycle: `o_NRE[k]`=0, `o_ADC`=0.
  - CONVERT, ADC_CYCLES cycles: `o_NRE[k]`=0, `o_ADC`=1.
  - GAP, 1 cycle: `o_NRE` all ones, `o_ADC`=0.
  - At most one `o_NRE` bit is ever low. `o_Expose`=0 and `o_Erase`=0 throughout READOUT.
  - The GAP of the last row is followed by IDLE. `o_Done`=1 in the first IDLE cycle and the erase counter restarts from 0.
- **`i_Abort`=1 in EXPOSURE or READOUT:** on the next edge go to IDLE with IDLE outputs, no `o_Done`, and the erase counter at 0. `i_Abort` is ignored in IDLE.
- **Simultaneous events:**
  - `i_Abort` has priority over `i_Init` and `i_Continuous`.
  - An abort that coincides with the last GAP cycle suppresses `o_Done`.
- `i_Init` is ignored while `o_Busy`=1.
- Reset low at any point forces reset values on the next edge, regardless of state.

## Timing
- Let edge 0 be the edge where a start condition is sampled in IDLE.
  - `o_Expose` is high in cycles 1..T.
  - READOUT spans cycles T+1..T+N_ROWS·(ADC_CYCLES+2).
  - `o_Done` is high in cycle T+N_ROWS·(ADC_CYCLES+2)+1.
- In continuous mode, consecutive frames are separated by exactly `ERASE_MIN` IDLE cycles. The `o_Done` cycle is the first of these.
- Abort latency: 1 edge.
- Counter widths: the exposure counter is EXP_W bits, the ADC counter is `$clog2(ADC_CYCLES+1)` bits, and the row counter is ROW_W bits. No counter wraps; each reloads explicitly.

## Test plan
All scenarios use `N_ROWS`=4, `ADC_CYCLES`=2, `ERASE_MIN`=3 unless stated.

- **Normal frame.** Release reset, then hold `i_Init`=1 from cycle 5 with T=5.
  - `o_Expose` high for 5 cycles, then 16 readout cycles.
  - `o_NRE` sequence 1110 (3 cycles), 1111, 1101 (3 cycles), 1111, and so on.
  - `o_ADC` high in cycles 2–3 of each row, `o_Row` steps 0..3, `o_Done` pulses once.
- **Zero exposure.** T=0: `o_Expose` high for exactly 1 cycle.
- **Early init.** Assert `i_Init` on the first cycle after reset: nothing happens until 3 IDLE cycles have elapsed, then EXPOSURE starts on the next edge.
- **Abort mid-readout.** Assert `i_Abort` during row 2 CONVERT: next cycle `o_Main_FSM`=00, `o_NRE`=1111, `o_ADC`=0, `o_Erase`=1, `o_Done` never pulses.
- **Continuous mode.** `i_Continuous`=1, T=4: two frames back-to-back with exactly 3 IDLE cycles between them and one `o_Done` per frame.
- **Reset mid-readout.** Drive `i_Reset_n`=0 during row 1: all outputs at reset values after the next edge. With `N_ROWS`=1, a full frame completes correctly with `o_Row` held at 0.
